// File: rtl/image_fade_renderer.sv
// Full-screen image renderer: scaled ROM address, palette colour scaled by a fade level.
// Latency: rom_address is combinational; RGB is registered one vga_clk after DrawX/DrawY.
// Backpressure: none; streams one pixel per vga_clk and never stalls.
module image_fade_renderer #(
  parameter int IMG_W       = 160,
  parameter int IMG_H       = 120,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int ADDR_BITS   = 15,
  parameter int IDX_BITS    = 3,
  parameter int FADE_FRAMES = 4,
  parameter int INIT_SHOWN  = 0
) (
  input  logic                 vga_clk,
  input  logic                 reset_n,
  input  logic [9:0]           DrawX,
  input  logic [9:0]           DrawY,
  input  logic                 blank,
  input  logic                 fade_in,
  input  logic                 fade_out,
  output logic [ADDR_BITS-1:0] rom_address,
  input  logic [IDX_BITS-1:0]  rom_q,
  input  logic [3:0]           pal_red,
  input  logic [3:0]           pal_green,
  input  logic [3:0]           pal_blue,
  output logic [3:0]           red,
  output logic [3:0]           green,
  output logic [3:0]           blue,
  output logic [1:0]           fade_state,
  output logic                 fade_done,
  output logic                 visible
);

  localparam int X_SCALE = SCREEN_W / IMG_W;
  localparam int Y_SCALE = SCREEN_H / IMG_H;
  localparam logic [9:0] X_SCALE_10  = 10'(X_SCALE);
  localparam logic [9:0] Y_SCALE_10  = 10'(Y_SCALE);
  localparam logic [9:0] SCREEN_W_10 = 10'(SCREEN_W);
  localparam logic [9:0] SCREEN_H_10 = 10'(SCREEN_H);

  localparam int CNT_W = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FADE_FRAMES - 1);

  localparam logic [4:0] LEVEL_MAX = 5'd16;

  typedef enum logic [1:0] {
    HIDDEN   = 2'd0,
    FADE_IN  = 2'd1,
    SHOWN    = 2'd2,
    FADE_OUT = 2'd3
  } fade_state_t;

  localparam fade_state_t INIT_STATE = (INIT_SHOWN != 0) ? SHOWN : HIDDEN;
  localparam logic [4:0]  INIT_LEVEL = (INIT_SHOWN != 0) ? LEVEL_MAX : 5'd0;

  fade_state_t      state, state_n;
  logic [4:0]       level, level_n;
  logic [CNT_W-1:0] frame_cnt, cnt_n;
  logic             done_n;
  logic             prev_origin;
  logic             origin;
  logic             frame_tick;
  logic             cmd_in, cmd_out;
  logic [9:0]       img_x, img_y;
  logic [8:0]       prod_r, prod_g, prod_b;

  // rom_q is consumed by the external palette, not here.
  logic unused_rom_q;
  assign unused_rom_q = ^rom_q;

  // Stretch-to-screen address: each source pixel covers an X_SCALE x Y_SCALE block.
  always_comb begin
    img_x = DrawX / X_SCALE_10;
    img_y = DrawY / Y_SCALE_10;
    if (DrawX >= SCREEN_W_10 || DrawY >= SCREEN_H_10) begin
      rom_address = '0;
    end else begin
      rom_address = ADDR_BITS'(img_x) + ADDR_BITS'(img_y) * ADDR_BITS'(IMG_W);
    end
  end

  // One tick per frame: rising edge of the origin condition, robust to a held origin.
  assign origin     = (DrawX == 10'd0) && (DrawY == 10'd0);
  assign frame_tick = origin && !prev_origin;

  // Conflicting simultaneous commands cancel each other.
  assign cmd_in  = fade_in && !fade_out;
  assign cmd_out = fade_out && !fade_in;

  // Fade products: 4-bit colour times 0..16 level, keep the top nibble.
  assign prod_r = {5'd0, pal_red}   * {4'd0, level};
  assign prod_g = {5'd0, pal_green} * {4'd0, level};
  assign prod_b = {5'd0, pal_blue}  * {4'd0, level};

  // Blank-gated, fade-scaled colour register.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      red   <= 4'd0;
      green <= 4'd0;
      blue  <= 4'd0;
    end else if (blank) begin
      red   <= 4'(prod_r >> 4);
      green <= 4'(prod_g >> 4);
      blue  <= 4'(prod_b >> 4);
    end else begin
      red   <= 4'd0;
      green <= 4'd0;
      blue  <= 4'd0;
    end
  end

  // Fade state, level, frame counter, done pulse and origin history.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      state       <= INIT_STATE;
      level       <= INIT_LEVEL;
      frame_cnt   <= '0;
      fade_done   <= 1'b0;
      prev_origin <= 1'b0;
    end else begin
      state       <= state_n;
      level       <= level_n;
      frame_cnt   <= cnt_n;
      fade_done   <= done_n;
      prev_origin <= origin;
    end
  end

  // Next-state logic: a valid command always beats a coincident frame tick.
  always_comb begin
    state_n = state;
    level_n = level;
    cnt_n   = frame_cnt;
    done_n  = 1'b0;
    case (state)
      HIDDEN: begin
        if (cmd_in) begin
          state_n = FADE_IN;
          cnt_n   = '0;
        end
      end
      FADE_IN: begin
        if (cmd_out) begin
          state_n = FADE_OUT;
          cnt_n   = '0;
        end else if (frame_tick) begin
          if (frame_cnt == CNT_LAST) begin
            cnt_n   = '0;
            // Clamp covers a reversal taken while still at full level.
            level_n = (level >= LEVEL_MAX) ? LEVEL_MAX : level + 5'd1;
            if (level_n == LEVEL_MAX) begin
              state_n = SHOWN;
              done_n  = 1'b1;
            end
          end else begin
            cnt_n = frame_cnt + CNT_W'(1);
          end
        end
      end
      SHOWN: begin
        if (cmd_out) begin
          state_n = FADE_OUT;
          cnt_n   = '0;
        end
      end
      FADE_OUT: begin
        if (cmd_in) begin
          state_n = FADE_IN;
          cnt_n   = '0;
        end else if (frame_tick) begin
          if (frame_cnt == CNT_LAST) begin
            cnt_n   = '0;
            // Clamp covers a reversal taken while still at zero level.
            level_n = (level == 5'd0) ? 5'd0 : level - 5'd1;
            if (level_n == 5'd0) begin
              state_n = HIDDEN;
              done_n  = 1'b1;
            end
          end else begin
            cnt_n = frame_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_n = state;
      end
    endcase
  end

  assign fade_state = state;
  assign visible    = (level != 5'd0);

endmodule

// File: tb/tb_image_fade_renderer.sv
// Scoreboard bench for image_fade_renderer: three parameterisations share the pixel stream.
// Stimulus pushes expected values tagged with the cycle they must appear on.
// A negedge monitor pops and compares each entry when its cycle comes up.
module tb_image_fade_renderer;

  logic vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  logic [9:0] draw_x = 10'd5;
  logic [9:0] draw_y = 10'd5;
  logic       blank  = 1'b0;
  logic [3:0] pal_r  = 4'd0;
  logic [3:0] pal_g  = 4'd0;
  logic [3:0] pal_b  = 4'd0;
  logic [2:0] rom_q  = 3'd0;

  logic rst_s = 1'b0, fin_s = 1'b0, fout_s = 1'b0;
  logic rst_f = 1'b0, fin_f = 1'b0, fout_f = 1'b0;
  logic rst_g = 1'b0, fin_g = 1'b0, fout_g = 1'b0;

  logic [14:0] addr_s, addr_f, addr_g;
  logic [3:0]  red_s, green_s, blue_s, red_f, green_f, blue_f, red_g, green_g, blue_g;
  logic [1:0]  state_s, state_f, state_g;
  logic        done_s, done_f, done_g, vis_s, vis_f, vis_g;

  // Starts SHOWN: address and colour-path checks.
  image_fade_renderer #(.FADE_FRAMES(4), .INIT_SHOWN(1)) dut_s (
    .vga_clk(vga_clk), .reset_n(rst_s), .DrawX(draw_x), .DrawY(draw_y), .blank(blank),
    .fade_in(fin_s), .fade_out(fout_s), .rom_address(addr_s), .rom_q(rom_q),
    .pal_red(pal_r), .pal_green(pal_g), .pal_blue(pal_b),
    .red(red_s), .green(green_s), .blue(blue_s),
    .fade_state(state_s), .fade_done(done_s), .visible(vis_s));

  // Two frames per level step: fade-in, fade-out and reversal checks.
  image_fade_renderer #(.FADE_FRAMES(2), .INIT_SHOWN(0)) dut_f (
    .vga_clk(vga_clk), .reset_n(rst_f), .DrawX(draw_x), .DrawY(draw_y), .blank(blank),
    .fade_in(fin_f), .fade_out(fout_f), .rom_address(addr_f), .rom_q(rom_q),
    .pal_red(pal_r), .pal_green(pal_g), .pal_blue(pal_b),
    .red(red_f), .green(green_f), .blue(blue_f),
    .fade_state(state_f), .fade_done(done_f), .visible(vis_f));

  // One frame per level step: held-origin, command-vs-tick and reset checks.
  image_fade_renderer #(.FADE_FRAMES(1), .INIT_SHOWN(0)) dut_g (
    .vga_clk(vga_clk), .reset_n(rst_g), .DrawX(draw_x), .DrawY(draw_y), .blank(blank),
    .fade_in(fin_g), .fade_out(fout_g), .rom_address(addr_g), .rom_q(rom_q),
    .pal_red(pal_r), .pal_green(pal_g), .pal_blue(pal_b),
    .red(red_g), .green(green_g), .blue(blue_g),
    .fade_state(state_g), .fade_done(done_g), .visible(vis_g));

  localparam int S_ADDR    = 0;
  localparam int S_RED_S   = 1;
  localparam int S_GRN_S   = 2;
  localparam int S_BLU_S   = 3;
  localparam int S_STATE_S = 4;
  localparam int S_VIS_S   = 5;
  localparam int S_RED_F   = 6;
  localparam int S_STATE_F = 7;
  localparam int S_VIS_F   = 8;
  localparam int S_DONE_F  = 9;
  localparam int S_DCNT_F  = 10;
  localparam int S_RED_G   = 11;
  localparam int S_STATE_G = 12;
  localparam int S_VIS_G   = 13;

  typedef struct {
    int    due;
    int    sel;
    int    exp;
    string name;
  } chk_t;

  chk_t q[$];
  int   cyc       = 0;
  int   n_checks  = 0;
  int   n_errors  = 0;
  int   done_cnt_f = 0;
  logic flush     = 1'b0;

  always @(posedge vga_clk) cyc <= cyc + 1;

  function automatic int get_val(input int sel);
    case (sel)
      S_ADDR:    return int'(addr_s);
      S_RED_S:   return int'(red_s);
      S_GRN_S:   return int'(green_s);
      S_BLU_S:   return int'(blue_s);
      S_STATE_S: return int'(state_s);
      S_VIS_S:   return int'(vis_s);
      S_RED_F:   return int'(red_f);
      S_STATE_F: return int'(state_f);
      S_VIS_F:   return int'(vis_f);
      S_DONE_F:  return int'(done_f);
      S_DCNT_F:  return done_cnt_f;
      S_RED_G:   return int'(red_g);
      S_STATE_G: return int'(state_g);
      S_VIS_G:   return int'(vis_g);
      default:   return -1;
    endcase
  endfunction

  // Monitor: counts fade_done pulses, then compares every entry due this cycle.
  always @(negedge vga_clk) begin
    int act;
    if (done_f) done_cnt_f++;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].due == cyc) begin
        n_checks++;
        act = get_val(q[i].sel);
        if (act != q[i].exp) begin
          n_errors++;
          $display("FAIL %s (cycle %0d): got %0d, expected %0d", q[i].name, cyc, act, q[i].exp);
        end
        q.delete(i);
      end else if (q[i].due < cyc) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s: check for cycle %0d was never evaluated", q[i].name, q[i].due);
        q.delete(i);
      end
    end
    if (flush) begin
      foreach (q[i]) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s: pending at end of run (due cycle %0d)", q[i].name, q[i].due);
      end
      q.delete();
    end
  end

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic expect_now(input int sel, input int exp, input string name);
    chk_t c;
    c.due = cyc; c.sel = sel; c.exp = exp; c.name = name;
    q.push_back(c);
  endtask

  task automatic expect_next(input int sel, input int exp, input string name);
    chk_t c;
    c.due = cyc + 1; c.sel = sel; c.exp = exp; c.name = name;
    q.push_back(c);
  endtask

  // One frame boundary: a cycle at the origin followed by pixel (1,0).
  task automatic tick();
    draw_x = 10'd0; draw_y = 10'd0;
    step();
    draw_x = 10'd1; draw_y = 10'd0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    step();
    step();
    // Reset state of all three instances.
    expect_now(S_STATE_S, 2, "rst_state_shown");
    expect_now(S_VIS_S,   1, "rst_vis_shown");
    expect_now(S_RED_S,   0, "rst_red_shown");
    expect_now(S_STATE_F, 0, "rst_state_hidden");
    expect_now(S_VIS_F,   0, "rst_vis_hidden");
    expect_now(S_RED_F,   0, "rst_red_hidden");
    expect_now(S_DONE_F,  0, "rst_done");
    expect_now(S_STATE_G, 0, "rst_state_g");
    rst_s = 1'b1; rst_f = 1'b1; rst_g = 1'b1;

    // Address mapping, including out-of-screen coordinates.
    draw_x = 10'd4;   draw_y = 10'd4;   expect_now(S_ADDR, 161,   "addr_4_4");   step();
    draw_x = 10'd639; draw_y = 10'd479; expect_now(S_ADDR, 19199, "addr_max");   step();
    draw_x = 10'd3;   draw_y = 10'd3;   expect_now(S_ADDR, 0,     "addr_3_3");   step();
    draw_x = 10'd700; draw_y = 10'd10;  expect_now(S_ADDR, 0,     "addr_x_oob"); step();
    draw_x = 10'd10;  draw_y = 10'd500; expect_now(S_ADDR, 0,     "addr_y_oob"); step();
    draw_x = 10'd13;  draw_y = 10'd9;   expect_now(S_ADDR, 323,   "addr_13_9");  step();

    // Colour path at full level, blanking and mid-line reset.
    draw_x = 10'd10; draw_y = 10'd10;
    blank = 1'b1; pal_r = 4'hF; pal_g = 4'h8; pal_b = 4'h1;
    expect_next(S_RED_S, 15, "rgb_full_r");
    expect_next(S_GRN_S, 8,  "rgb_full_g");
    expect_next(S_BLU_S, 1,  "rgb_full_b");
    step();
    blank = 1'b0;
    expect_next(S_RED_S, 0, "rgb_blank_r");
    expect_next(S_GRN_S, 0, "rgb_blank_g");
    expect_next(S_BLU_S, 0, "rgb_blank_b");
    step();
    blank = 1'b1; rst_s = 1'b0;
    expect_next(S_RED_S,   0, "rgb_reset_r");
    expect_next(S_STATE_S, 2, "reset_shown_state");
    step();
    rst_s = 1'b1;
    expect_next(S_RED_S, 15, "rgb_after_reset_r");
    step();

    // Fade-in with two frames per level step.
    pal_r = 4'hF; pal_g = 4'hF; pal_b = 4'hF;
    fin_f = 1'b1;
    expect_next(S_STATE_F, 1, "fade_in_start");
    step();
    fin_f = 1'b0;
    repeat (16) tick();
    expect_now(S_RED_F,   7, "level8_red");
    expect_now(S_STATE_F, 1, "level8_state");
    expect_now(S_VIS_F,   1, "level8_visible");
    repeat (16) tick();
    expect_now(S_STATE_F, 2,  "shown_state");
    expect_now(S_RED_F,   15, "shown_red");
    expect_now(S_DCNT_F,  1,  "shown_done_once");

    // Fade-out to level 11, then reverse.
    fout_f = 1'b1;
    expect_next(S_STATE_F, 3, "fade_out_start");
    step();
    fout_f = 1'b0;
    repeat (10) tick();
    expect_now(S_RED_F,   10, "level11_red");
    expect_now(S_STATE_F, 3,  "level11_state");
    fin_f = 1'b1;
    expect_next(S_STATE_F, 1,  "reverse_state");
    expect_next(S_RED_F,   10, "reverse_level_kept");
    step();
    fin_f = 1'b0;
    repeat (9) tick();
    expect_now(S_STATE_F, 1,  "reverse_9ticks_state");
    expect_now(S_RED_F,   14, "reverse_9ticks_red");
    expect_now(S_DCNT_F,  1,  "reverse_no_done");
    tick();
    expect_now(S_STATE_F, 2,  "reverse_shown_state");
    expect_now(S_RED_F,   15, "reverse_shown_red");
    expect_now(S_DCNT_F,  2,  "reverse_shown_done");

    // fade_in while SHOWN is ignored.
    fin_f = 1'b1;
    expect_next(S_STATE_F, 2, "fade_in_in_shown");
    step();
    fin_f = 1'b0;
    step();
    expect_now(S_DCNT_F, 2, "fade_in_in_shown_no_done");
    expect_now(S_DONE_F, 0, "fade_in_in_shown_done_low");

    // Simultaneous commands in HIDDEN are both ignored.
    fin_g = 1'b1; fout_g = 1'b1;
    expect_next(S_STATE_G, 0, "both_cmds_state");
    step();
    fin_g = 1'b0; fout_g = 1'b0;
    tick();
    tick();
    expect_now(S_STATE_G, 0, "both_cmds_still_hidden");
    expect_now(S_VIS_G,   0, "both_cmds_invisible");

    // Held origin counts as one tick.
    draw_x = 10'd5; draw_y = 10'd5;
    fin_g = 1'b1;
    expect_next(S_STATE_G, 1, "g_fade_in_start");
    step();
    fin_g = 1'b0;
    draw_x = 10'd0; draw_y = 10'd0;
    repeat (5) step();
    draw_x = 10'd1;
    step();
    expect_now(S_RED_G, 0, "held_origin_level1_red");
    expect_now(S_VIS_G, 1, "held_origin_visible");
    tick();
    expect_now(S_RED_G, 1, "level2_red");

    // Command coincident with a tick: command wins, level unchanged.
    draw_x = 10'd0; draw_y = 10'd0;
    fout_g = 1'b1;
    expect_next(S_STATE_G, 3, "cmd_vs_tick_state");
    step();
    fout_g = 1'b0;
    draw_x = 10'd1;
    expect_next(S_RED_G, 1, "cmd_vs_tick_level_kept");
    step();

    // Reset mid-fade.
    rst_g = 1'b0;
    expect_next(S_STATE_G, 0, "midfade_reset_state");
    expect_next(S_VIS_G,   0, "midfade_reset_visible");
    expect_next(S_RED_G,   0, "midfade_reset_red");
    step();
    rst_g = 1'b1;
    step();
    step();

    flush = 1'b1;
    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/image_fade_renderer.md
Name: image_fade_renderer

Overview:
- Full-screen image renderer for end-of-game and title screens. It is the parametrised successor of the fixed 160x120 stretch-to-screen renderers.
- It generates the scaled ROM address from DrawX/DrawY and takes the ROM index back through an external palette. It outputs blank-gated RGB scaled by a fade level.
- A fade-in/fade-out state machine steps the level once per N frames.
- It sits between the VGA controller and the colour mux. The ROM and palette stay external so that one renderer serves any image.

Parameters:
- IMG_W, 160, source image width in pixels; SCREEN_W must be an integer multiple of it.
- IMG_H, 120, source image height in pixels; SCREEN_H must be an integer multiple of it.
- SCREEN_W, 640, visible width.
- SCREEN_H, 480, visible height.
- ADDR_BITS, 15, ROM address width; must satisfy IMG_W*IMG_H <= 2^ADDR_BITS.
- IDX_BITS, 3, palette index width.
- FADE_FRAMES, 4, frames per fade-level step (>=1).
- INIT_SHOWN, 0, reset state: 0 = HIDDEN with level 0; 1 = SHOWN with level 16.

Ports:
- vga_clk  in  1  pixel clock; sole clock.
- reset_n  in  1  synchronous, active-low reset.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- blank  in  1  1 = active video.
- fade_in  in  1  one-cycle command pulse.
- fade_out  in  1  one-cycle command pulse.
- rom_address  out  ADDR_BITS  to external ROM; the ROM is clocked on ~vga_clk.
- rom_q  in  IDX_BITS  ROM data; unused by this block, routed to the palette at top level.
- pal_red  in  4  external palette output for rom_q.
- pal_green  in  4  external palette output for rom_q.
- pal_blue  in  4  external palette output for rom_q.
- red  out  4  registered output colour.
- green  out  4  registered output colour.
- blue  out  4  registered output colour.
- fade_state  out  2  0 HIDDEN, 1 FADE_IN, 2 SHOWN, 3 FADE_OUT.
- fade_done  out  1  one-cycle pulse when FADE_IN reaches SHOWN or FADE_OUT reaches HIDDEN.
- visible  out  1  1 when level != 0.

Behaviour:
- Address:
  - Combinational: rom_address = DrawX/(SCREEN_W/IMG_W) + (DrawY/(SCREEN_H/IMG_H))*IMG_W.
  - Integer division by a constant ratio.
  - If DrawX >= SCREEN_W or DrawY >= SCREEN_H, rom_address = 0.
- Colour path:
  - ROM reads on the negedge; pal_* is valid before the next posedge.
  - On each posedge: if blank = 1, red = (pal_red*level)>>4, likewise green and blue; otherwise red/green/blue = 0.
  - Products are 9 bits wide; level is 5 bits in the range 0..16.
  - level 16 passes the palette value unchanged.
  - Total latency: one vga_clk from DrawX/DrawY to RGB.
- Frame tick:
  - frame_tick = (DrawX==0 && DrawY==0) && !prev_origin, where prev_origin is the registered origin condition.
  - Exactly one tick per frame, even if the origin is held for several cycles.
- FSM, updated on posedge:
  - HIDDEN: fade_in goes to FADE_IN and clears frame_cnt.
  - FADE_IN: on each frame_tick, frame_cnt++. When frame_cnt reaches FADE_FRAMES-1, clear it and increment level. When level becomes 16, go to SHOWN and pulse fade_done. fade_out goes to FADE_OUT from the current level and clears frame_cnt.
  - SHOWN: fade_out goes to FADE_OUT and clears frame_cnt.
  - FADE_OUT: mirror of FADE_IN; level decrements, and at level 0 go to HIDDEN and pulse fade_done. fade_in reverses to FADE_IN.
  - fade_in in SHOWN or FADE_IN is ignored. fade_out in HIDDEN or FADE_OUT is ignored.
  - fade_in and fade_out asserted in the same cycle: both ignored.
  - A command in the same cycle as a frame_tick: the command wins. The tick is not counted, and level is unchanged that cycle.
  - The level update takes effect on RGB starting with the pixel after the tick cycle, i.e. from pixel (1,0) onward.
- Reset (reset_n = 0 at a posedge), mid-frame or mid-fade:
  - red/green/blue = 0, fade_done = 0, frame_cnt = 0, prev_origin = 0.
  - INIT_SHOWN=0: fade_state = HIDDEN, level = 0, visible = 0.
  - INIT_SHOWN=1: fade_state = SHOWN, level = 16, visible = 1.
  - rom_address stays combinational and is unaffected by reset.

Test Plan:
- Address mapping, defaults: DrawX=4,DrawY=4 -> 161; 639,479 -> 19199; 3,3 -> 0; 700,10 -> 0.
- INIT_SHOWN=1, blank=1, pal=F/8/1: RGB one cycle later = F/8/1. Same with blank=0 -> 0/0/0. reset_n=0 mid-line -> RGB 0 on the next cycle.
- FADE_FRAMES=2, INIT_SHOWN=0, pulse fade_in, run frames with pal=F/F/F:
  - level 8 after 16 ticks; red=7.
  - SHOWN with fade_done pulsed exactly once after 32 ticks; red=F.
- From SHOWN, pulse fade_out; after 10 ticks (level 11) pulse fade_in:
  - state FADE_IN, level 11, no fade_done.
  - reaches SHOWN 10 ticks later.
- Pulse fade_in and fade_out in the same cycle in HIDDEN -> remains HIDDEN. fade_in in SHOWN -> no change, no fade_done.
- Hold DrawX=0,DrawY=0 for 5 cycles during FADE_IN with FADE_FRAMES=1 -> level increases by exactly 1. Reset asserted mid-fade -> HIDDEN, level 0, visible=0.
